inject_buf: RTL



---
 rtl/inject_buf_pkg.sv | 16 +
 rtl/inject_buf_fifo.sv | 59 +++++
 rtl/inject_buf.sv | 97 +++++++++
 3 files changed

// File: rtl/inject_buf_pkg.sv
// Shared types and defaults for the local-port injection buffer:
// flit width, valid/age field placement and the injection state encoding.
package inject_buf_pkg;

  localparam int DATA_W      = 64;
  localparam int AGE_W_DEF   = 8;
  localparam int AGE_LSB_DEF = 0;
  localparam int VLD_BIT_DEF = 63;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_READY = 2'd1,
    ST_WAIT  = 2'd2
  } inj_state_e;

endpackage

// File: rtl/inject_buf_fifo.sv
// Injection FIFO: flit storage, wrapping pointers, registered occupancy and full.
// Push/pop qualification is done by the parent; this block only applies them.
module inject_buf_fifo
  import inject_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] head_o,
  output logic [OCC_W-1:0]  occ_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full_q, full_d;

  always_comb begin
    wr_ptr_d = push_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_i  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d    = occ_q;
    if (push_i && !pop_i)      occ_d = occ_q + OCC_W'(1);
    else if (!push_i && pop_i) occ_d = occ_q - OCC_W'(1);
    full_d   = (occ_d == OCC_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      full_q   <= full_d;
    end
  end

  // Storage carries no reset; contents are meaningless until pushed.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;
  assign full_o = full_q;

endmodule

// File: rtl/inject_buf.sv
// Local-port injection buffer: queues node flits and injects one per granted
// slot, stamping valid and age. Optional macro INJ_STALL_CNT_EN adds stall_cnt.
module inject_buf
  import inject_buf_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int AGE_W   = AGE_W_DEF,
  parameter int AGE_LSB = AGE_LSB_DEF,
  parameter int VLD_BIT = VLD_BIT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       full,
  input  logic                       slot_free,
  output logic [DATA_W-1:0]          inj_flit,
  output logic [$clog2(DEPTH):0]     occ
`ifdef INJ_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] head;
  logic [OCC_W-1:0]  occ_w;
  logic              full_w;
  logic              push, pop, empty_next;

  logic [AGE_W-1:0]  ts_q, ts_d;
  logic [DATA_W-1:0] inj_flit_q, inj_flit_d;
  inj_state_e        state_q, state_d;

  function automatic logic [DATA_W-1:0] stamp(input logic [DATA_W-1:0] f,
                                              input logic [AGE_W-1:0]  age);
    logic [DATA_W-1:0] r;
    r                    = f;
    r[VLD_BIT]           = 1'b1;
    r[AGE_LSB +: AGE_W]  = age;
    return r;
  endfunction

  inject_buf_fifo #(.DEPTH(DEPTH), .OCC_W(OCC_W)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (push),
    .pop_i     (pop),
    .wr_data_i (wr_data),
    .head_o    (head),
    .occ_o     (occ_w),
    .full_o    (full_w)
  );

  // Full is the pre-edge value, so a push at full is refused even when popping.
  always_comb begin
    push       = wr_en && !full_w;
    pop        = slot_free && (occ_w != '0);
    empty_next = !push && ((occ_w == '0) || ((occ_w == OCC_W'(1)) && pop));
    ts_d       = ts_q + AGE_W'(1);
    inj_flit_d = pop ? stamp(head, ts_q) : '0;
    if (empty_next)                      state_d = ST_EMPTY;
    else if (occ_w != '0 && !slot_free)  state_d = ST_WAIT;
    else                                 state_d = ST_READY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q       <= '0;
      inj_flit_q <= '0;
      state_q    <= ST_EMPTY;
    end else begin
      ts_q       <= ts_d;
      inj_flit_q <= inj_flit_d;
      state_q    <= state_d;
    end
  end

`ifdef INJ_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if (state_d == ST_WAIT && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign inj_flit = inj_flit_q;
  assign occ      = occ_w;
  assign full     = full_w;

endmodule
